tbec_decoder_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-word combinational TBEC decoder.
- Decodes LANES independent 32-bit TBEC codewords per beat, each carrying 16 data bits, using the Silva et al. 2023 three-region correction rule.
- Registered valid/ready stream interface with 2-cycle latency, full backpressure and optional per-lane correction counters.
- Sits between the memory/link read path and the consumer.

---
 rtl/tbec_decoder_pipe.sv | 179 +++++++++++++++++
 tb/tb_tbec_decoder_pipe.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tbec_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tbec_decoder_pipe
// Purpose  : LANES-wide, two-stage pipelined TBEC decoder (32-bit codeword,
//            16 data bits per lane) using the three-region correction rule.
//            Valid/ready stream with full backpressure, latency 2 cycles.
// Options  : define TBEC_DEC_ERR_CNT_EN to build per-lane saturating
//            correction counters (corr_cnt, cleared by cnt_clear).
// Revision : 1.0 - initial pipelined release
// ============================================================================
module tbec_decoder_pipe #(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [32*LANES-1:0]      in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [16*LANES-1:0]      out_data,
    output logic [2*LANES-1:0]       out_err_code,
    output logic                     out_any_corr,
    input  logic                     cnt_clear,
    output logic [CNT_W*LANES-1:0]   corr_cnt
);

    // Data bit order inside a lane: d[15:12]=row1 (A1 B1 C1 D1) ... d[3:0]=row4.
    // Result order matches the received check field w[15:0]:
    // DI1 DI4 DI2 DI3 | P1 P4 P2 P3 | XA13 XA24 XB13 XB24 XC13 XC24 XD13 XD24.
    function automatic logic [15:0] calc_checks(input logic [15:0] d);
        logic [3:0] x13;
        logic [3:0] x24;
        x13 = d[15:12] ^ d[7:4];
        x24 = d[11:8]  ^ d[3:0];
        return {d[15] ^ d[10] ^ d[13] ^ d[8],
                d[3]  ^ d[6]  ^ d[1]  ^ d[4],
                d[11] ^ d[14] ^ d[9]  ^ d[12],
                d[7]  ^ d[2]  ^ d[5]  ^ d[0],
                d[15] ^ d[11] ^ d[14] ^ d[10],
                d[5]  ^ d[1]  ^ d[4]  ^ d[0],
                d[13] ^ d[9]  ^ d[12] ^ d[8],
                d[7]  ^ d[3]  ^ d[6]  ^ d[2],
                x13[3], x24[3], x13[2], x24[2],
                x13[1], x24[1], x13[0], x24[0]};
    endfunction

    // Applies the region rule to one lane; returns {err_code, corrected data}.
    function automatic logic [17:0] decode_lane(input logic [15:0] d, input logic [15:0] s);
        logic [3:0]  x13;
        logic [3:0]  x24;
        logic [3:0]  nx;
        logic [2:0]  s12;
        logic [2:0]  s34;
        logic        fix;
        logic [15:0] r;
        logic [1:0]  code;
        x13 = {s[7], s[5], s[3], s[1]};
        x24 = {s[6], s[4], s[2], s[0]};
        nx  = '0;
        for (int k = 0; k < 8; k++) begin
            nx = nx + {3'b000, s[k]};
        end
        // s12 gathers DI1, DI2, P1, P2; s34 gathers DI3, DI4, P3, P4
        s12 = {2'b00, s[15]} + {2'b00, s[13]} + {2'b00, s[11]} + {2'b00, s[9]};
        s34 = {2'b00, s[14]} + {2'b00, s[12]} + {2'b00, s[10]} + {2'b00, s[8]};
        fix = ((|s[15:12] && |s[11:8]) || (nx > 4'd1)) && !(s[8] && (nx > 4'd1));
        r    = d;
        code = 2'b00;
        if (fix) begin
            if (s12 > s34) begin
                r[15:12] = d[15:12] ^ x13;
                r[11:8]  = d[11:8]  ^ x24;
                code     = 2'b01;
            end else if (s12 < s34) begin
                r[7:4]   = d[7:4]   ^ x13;
                r[3:0]   = d[3:0]   ^ x24;
                code     = 2'b10;
            end else begin
                r[11:8]  = d[11:8]  ^ x24;
                r[7:4]   = d[7:4]   ^ x13;
                code     = 2'b11;
            end
        end
        return {code, r};
    endfunction

    logic                   s1_valid;
    logic                   s2_valid;
    logic                   s1_load;
    logic                   s2_load;
    logic [16*LANES-1:0]    s1_data;
    logic [16*LANES-1:0]    s1_syn;
    logic [16*LANES-1:0]    in_syn;
    logic [16*LANES-1:0]    dec_data;
    logic [2*LANES-1:0]     dec_code;

    // S2 frees up when empty or drained; S1 can refill behind a moving S2,
    // so a bubble in S2 never blocks the input.
    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = s2_valid;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign in_syn[16*i +: 16] = calc_checks(in_data[32*i+16 +: 16]) ^ in_data[32*i +: 16];
        assign {dec_code[2*i +: 2], dec_data[16*i +: 16]} =
            decode_lane(s1_data[16*i +: 16], s1_syn[16*i +: 16]);
    end

    // Stage 1: capture raw data and syndromes of an accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_syn   <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data_data(in_data);
                s1_syn  <= in_syn;
            end
        end
    end

    // Gathers the 16 data bits of every lane into a packed vector
    function automatic logic [16*LANES-1:0] in_data_data(input logic [32*LANES-1:0] w);
        logic [16*LANES-1:0] d;
        d = '0;
        for (int k = 0; k < LANES; k++) begin
            d[16*k +: 16] = w[32*k+16 +: 16];
        end
        return d;
    endfunction

    // Stage 2: register corrected data and codes; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_data     <= '0;
            out_err_code <= '0;
            out_any_corr <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= dec_data;
                out_err_code <= dec_code;
                out_any_corr <= |dec_code;
            end
        end
    end

`ifdef TBEC_DEC_ERR_CNT_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_cnt
        logic [CNT_W-1:0] cnt;
        // Per-lane saturating count of corrected beats; clear wins over increment
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt <= '0;
            end else if (cnt_clear) begin
                cnt <= '0;
            end else if (out_fire && (out_err_code[2*i +: 2] != 2'b00) && (cnt != {CNT_W{1'b1}})) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
        assign corr_cnt[CNT_W*i +: CNT_W] = cnt;
    end
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    assign corr_cnt         = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tbec_decoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tbec_decoder_pipe
// Purpose  : Scoreboard bench for tbec_decoder_pipe: a single-lane instance
//            (CNT_W=2) for directed decode, latency, counter and reset
//            scenarios, and a four-lane instance for randomised backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tbec_decoder_pipe;
`ifdef TBEC_DEC_ERR_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // single-lane instance
    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [15:0] a_out_data;
    logic [1:0]  a_code;
    logic        a_any;
    logic        a_cnt_clear = 1'b0;
    logic [1:0]  a_cnt;
    logic [17:0] a_exp = '0;

    // four-lane instance
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [127:0] b_in_data = '0;
    logic         b_out_valid;
    logic         b_out_ready = 1'b0;
    logic [63:0]  b_out_data;
    logic [7:0]   b_code;
    logic         b_any;
    logic [63:0]  b_cnt;
    logic [71:0]  b_exp = '0;

    int checks = 0;
    int errors = 0;
    int received4 = 0;
    logic [17:0] q1[$];
    logic [71:0] q4[$];

    tbec_decoder_pipe #(.LANES(1), .CNT_W(2)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_err_code(a_code), .out_any_corr(a_any),
        .cnt_clear(a_cnt_clear), .corr_cnt(a_cnt)
    );

    tbec_decoder_pipe #(.LANES(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_err_code(b_code), .out_any_corr(b_any),
        .cnt_clear(1'b0), .corr_cnt(b_cnt)
    );

    // Reference check bits, computed from named cell bits a..d of rows 1..4
    function automatic logic [15:0] tb_checks(input logic [15:0] d);
        logic a[1:4];
        logic b[1:4];
        logic c[1:4];
        logic e[1:4];
        for (int j = 1; j <= 4; j++) begin
            a[j] = d[19-4*j];
            b[j] = d[18-4*j];
            c[j] = d[17-4*j];
            e[j] = d[16-4*j];
        end
        return {a[1]^b[2]^c[1]^e[2], a[4]^b[3]^c[4]^e[3], a[2]^b[1]^c[2]^e[1], a[3]^b[4]^c[3]^e[4],
                a[1]^a[2]^b[1]^b[2], c[3]^c[4]^e[3]^e[4], c[1]^c[2]^e[1]^e[2], a[3]^a[4]^b[3]^b[4],
                a[1]^a[3], a[2]^a[4], b[1]^b[3], b[2]^b[4], c[1]^c[3], c[2]^c[4], e[1]^e[3], e[2]^e[4]};
    endfunction

    // Reference decoder: returns {code, data}
    function automatic logic [17:0] ref_decode(input logic [31:0] w);
        logic [15:0] s;
        logic [15:0] dd;
        logic [3:0]  m13;
        logic [3:0]  m24;
        int          nx;
        int          s12;
        int          s34;
        bit          corr;
        s   = tb_checks(w[31:16]) ^ w[15:0];
        dd  = w[31:16];
        m13 = {s[7], s[5], s[3], s[1]};
        m24 = {s[6], s[4], s[2], s[0]};
        nx  = 0;
        for (int k = 0; k < 8; k++) nx += int'(s[k]);
        s12 = int'(s[15]) + int'(s[13]) + int'(s[11]) + int'(s[9]);
        s34 = int'(s[14]) + int'(s[12]) + int'(s[10]) + int'(s[8]);
        corr = (((s[15:12] != 4'h0) && (s[11:8] != 4'h0)) || nx > 1) && !(s[8] && nx > 1);
        if (!corr)      return {2'b00, dd};
        if (s12 > s34)  return {2'b01, dd[15:12] ^ m13, dd[11:8] ^ m24, dd[7:0]};
        if (s12 < s34)  return {2'b10, dd[15:8], dd[7:4] ^ m13, dd[3:0] ^ m24};
        return {2'b11, dd[15:12], dd[11:8] ^ m24, dd[7:4] ^ m13, dd[3:0]};
    endfunction

    // Valid codeword with up to two random bit flips
    function automatic logic [31:0] rand_word();
        logic [15:0] d;
        logic [31:0] w;
        d = 16'($urandom);
        w = {d, tb_checks(d)};
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) w[$urandom_range(0, 31)] ^= 1'b1;
        return w;
    endfunction

    // Scoreboard for the single-lane instance
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            q1.delete();
        end else begin
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL lane1_extra_beat: got code %b data %h, expected no beat", a_code, a_out_data);
                end else begin
                    logic [17:0] e;
                    e = q1.pop_front();
                    if ({a_code, a_out_data} !== e) begin
                        errors++;
                        $display("FAIL lane1_decode: got code %b data %h, expected code %b data %h",
                                 a_code, a_out_data, e[17:16], e[15:0]);
                    end
                    checks++;
                    if (a_any !== (e[17:16] != 2'b00)) begin
                        errors++;
                        $display("FAIL lane1_any_corr: got %b, expected %b", a_any, e[17:16] != 2'b00);
                    end
                end
            end
            if (a_in_valid && a_in_ready) q1.push_back(a_exp);
        end
    end

    // Scoreboard for the four-lane instance, including stall stability
    logic        b_stalled = 1'b0;
    logic [74:0] b_hold = '0;
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            q4.delete();
            b_stalled = 1'b0;
        end else begin
            if (b_stalled) begin
                checks++;
                if ({b_out_valid, b_any, b_code, b_out_data} !== b_hold) begin
                    errors++;
                    $display("FAIL lane4_stall_hold: got %h, expected %h",
                             {b_out_valid, b_any, b_code, b_out_data}, b_hold);
                end
            end
            if (b_out_valid && b_out_ready) begin
                received4++;
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL lane4_extra_beat: got code %b data %h, expected no beat", b_code, b_out_data);
                end else begin
                    logic [71:0] e;
                    e = q4.pop_front();
                    if ({b_code, b_out_data} !== e || b_any !== (|e[71:64])) begin
                        errors++;
                        $display("FAIL lane4_decode: got code %b data %h any %b, expected code %b data %h any %b",
                                 b_code, b_out_data, b_any, e[71:64], e[63:0], |e[71:64]);
                    end
                end
            end
            if (b_in_valid && b_in_ready) q4.push_back(b_exp);
            b_stalled = b_out_valid && !b_out_ready;
            b_hold    = {b_out_valid, b_any, b_code, b_out_data};
        end
    end

    // Drives one cycle of stimulus on the single-lane instance
    task automatic drive1(input bit v, input logic [31:0] d, input logic [17:0] e,
                          input bit ordy, input bit clr);
        @(negedge clk);
        a_in_valid  = v;
        a_in_data   = d;
        a_exp       = e;
        a_out_ready = ordy;
        a_cnt_clear = clr;
    endtask

    task automatic drain1();
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        for (int i = 0; i < 20 && q1.size() != 0; i++) drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({a_out_valid, a_out_data, a_code, a_any, a_cnt} !== 22'h0) begin
            errors++;
            $display("FAIL reset_lane1: got %h, expected 0", {a_out_valid, a_out_data, a_code, a_any, a_cnt});
        end
        checks++;
        if ({b_out_valid, b_out_data, b_code, b_any, b_cnt} !== 138'h0) begin
            errors++;
            $display("FAIL reset_lane4: got %h, expected 0", {b_out_valid, b_out_data, b_code, b_any, b_cnt});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b%b, expected 11", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_latency();
        drive1(1'b1, 32'h0000_0000, {2'b00, 16'h0000}, 1'b1, 1'b0);
        #1;
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL latency_accept: got in_ready %b, expected 1", a_in_ready);
        end
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_cycle1: got out_valid %b, expected 0", a_out_valid);
        end
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_cycle2: got out_valid %b, expected 1", a_out_valid);
        end
        drain1();
    endtask

    task automatic test_regions();
        logic [31:0] words [5] = '{32'h8000_0000, 32'h0080_0000, 32'h0220_0000, 32'h0880_0000, 32'h0000_0000};
        logic [17:0] exps  [5] = '{{2'b01, 16'h0000}, {2'b10, 16'h0000}, {2'b11, 16'h0000},
                                   {2'b00, 16'h0880}, {2'b00, 16'h0000}};
        for (int i = 0; i < 5; i++) begin
            drive1(1'b1, words[i], exps[i], 1'b1, 1'b0);
            drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        end
        drain1();
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL regions_drain: got %0d pending, expected 0", q1.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        int sent = 0;
        w = rand_word();
        for (int c = 0; c < 1000 && sent < 40; c++) begin
            drive1(1'b1, w, ref_decode(w), 1'($urandom_range(0, 1)), 1'b0);
            #1;
            if (a_in_ready) begin
                sent++;
                w = rand_word();
            end
        end
        drain1();
        checks++;
        if (sent != 40 || q1.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: got %0d sent %0d pending, expected 40 sent 0 pending", sent, q1.size());
        end
    endtask

    task automatic test_counters();
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b1);
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) drive1(1'b1, 32'h8000_0000, {2'b01, 16'h0}, 1'b1, 1'b0);
        drain1();
        #1;
        checks++;
        if (a_cnt !== 2'(2 * CNT_EN)) begin
            errors++;
            $display("FAIL cnt_two: got %0d, expected %0d", a_cnt, 2 * CNT_EN);
        end
        for (int i = 0; i < 3; i++) drive1(1'b1, 32'h8000_0000, {2'b01, 16'h0}, 1'b1, 1'b0);
        drain1();
        #1;
        checks++;
        if (a_cnt !== 2'(3 * CNT_EN)) begin
            errors++;
            $display("FAIL cnt_saturate: got %0d, expected %0d", a_cnt, 3 * CNT_EN);
        end
        drive1(1'b1, 32'h8000_0000, {2'b01, 16'h0}, 1'b1, 1'b0);
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b1);
        #1;
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL cnt_clear_handshake: got out_valid %b, expected 1", a_out_valid);
        end
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if (a_cnt !== 2'd0) begin
            errors++;
            $display("FAIL cnt_clear_priority: got %0d, expected 0", a_cnt);
        end
    endtask

    task automatic test_reset_midburst();
        for (int i = 0; i < 2; i++) drive1(1'b1, 32'h8000_0000, {2'b01, 16'h0}, 1'b1, 1'b0);
        drain1();
        for (int i = 0; i < 3; i++) drive1(1'b1, 32'h0080_0000, {2'b10, 16'h0}, 1'b1, 1'b0);
        #1;
        checks++;
        if (a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midburst_active: got out_valid %b, expected 1", a_out_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_cnt !== 2'd0 || a_code !== 2'b00) begin
            errors++;
            $display("FAIL midburst_reset: got valid %b cnt %0d code %b, expected 0 0 00", a_out_valid, a_cnt, a_code);
        end
        a_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        drive1(1'b0, 32'h0, 18'h0, 1'b1, 1'b0);
        #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midburst_discard: got out_valid %b, expected 0", a_out_valid);
        end
    endtask

    // Alternates the fixed four-lane pattern with random codewords per lane
    task automatic make_beat4(input int n, output logic [127:0] w, output logic [71:0] e);
        if (n % 2 == 0) begin
            w = {32'h0220_0000, 32'h0080_0000, 32'h0000_0000, 32'h8000_0000};
            e = {8'b11_10_00_01, 64'h0};
        end else begin
            for (int l = 0; l < 4; l++) begin
                logic [31:0] cw;
                logic [17:0] r;
                cw = rand_word();
                r  = ref_decode(cw);
                w[32*l +: 32]   = cw;
                e[16*l +: 16]   = r[15:0];
                e[64+2*l +: 2]  = r[17:16];
            end
        end
    endtask

    task automatic test_lanes4_backpressure();
        logic [127:0] w;
        logic [71:0]  e;
        int sent = 0;
        int cyc  = 0;
        make_beat4(0, w, e);
        while ((sent < 200 || q4.size() != 0) && cyc < 4000) begin
            @(negedge clk);
            b_in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
            b_in_data   = w;
            b_exp       = e;
            b_out_ready = 1'($urandom_range(0, 1));
            #1;
            if (b_in_valid && b_in_ready) begin
                sent++;
                make_beat4(sent, w, e);
            end
            cyc++;
        end
        @(negedge clk);
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        #3;
        checks++;
        if (sent != 200 || received4 != 200 || q4.size() != 0) begin
            errors++;
            $display("FAIL lanes4_count: got sent %0d received %0d pending %0d, expected 200 200 0",
                     sent, received4, q4.size());
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_latency();
        test_regions();
        test_back_to_back();
        test_counters();
        test_reset_midburst();
        test_lanes4_backpressure();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 500000");
        $fatal(1);
    end

endmodule
`default_nettype wire
